// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: branch-unit redirect inputs, instruction-memory port and decode-side queue head.
interface pc_fetch_if;
    logic [1:0]  pc_c;
    logic [12:0] b_im_in;
    logic [31:0] br_pc;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_addr;
    logic        misalign;

    modport master (
        input  pc_c, b_im_in, br_pc, jump_target, imem_ack, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst_out, pc_addr, misalign
    );

    modport slave (
        output pc_c, b_im_in, br_pc, jump_target, imem_ack, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst_out, pc_addr, misalign
    );
endinterface

// File: rtl/pc_fetch.sv
// PC + one-outstanding imem fetch into a 2-entry queue; same-cycle ack gives inst_valid one cycle after imem_req.
// Decode backpressure (inst_ready low) fills the queue, then requests stop until space frees up.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    pc_fetch_if.master  bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] kill_addr;
    logic [1:0]  count;
    logic [31:0] head_pc, head_inst, tail_pc, tail_inst;
    logic        misalign_q;

    logic        redirect;
    logic [31:0] tgt_raw;
    logic [31:0] tgt_aligned;
    logic        pop;
    logic        push;
    logic [1:0]  cnt_pop;
    logic [1:0]  cnt_after;

    assign redirect    = (bus.pc_c == 2'd1) || (bus.pc_c == 2'd2);
    assign tgt_raw     = (bus.pc_c == 2'd2) ? bus.br_pc + {{19{bus.b_im_in[12]}}, bus.b_im_in}
                                            : bus.jump_target & ~32'd1;
    assign tgt_aligned = tgt_raw & ~32'd3;
    assign pop         = (count != 2'd0) && bus.inst_ready;
    assign push        = (state == REQ) && bus.imem_ack && !redirect;
    assign cnt_pop     = count - {1'b0, pop};
    assign cnt_after   = cnt_pop + {1'b0, push};

    assign bus.inst_valid = (count != 2'd0);
    assign bus.inst_out   = head_inst;
    assign bus.pc_addr    = head_pc;
    assign bus.misalign   = misalign_q;
    // A killed fetch keeps presenting its original address until memory answers.
    assign bus.imem_addr  = (state == KILL) ? kill_addr : fetch_pc;

    always_comb begin
        state_nxt    = state;
        bus.imem_req = 1'b0;
        case (state)
            IDLE: begin
                if (redirect || cnt_pop != 2'd2)
                    state_nxt = REQ;
            end
            REQ: begin
                bus.imem_req = 1'b1;
                if (redirect)
                    state_nxt = bus.imem_ack ? REQ : KILL;
                else if (bus.imem_ack)
                    state_nxt = (cnt_after != 2'd2) ? REQ : IDLE;
            end
            KILL: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack)
                    state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            kill_addr  <= RESET_PC;
            count      <= 2'd0;
            head_pc    <= RESET_PC;
            head_inst  <= NOP;
            tail_pc    <= RESET_PC;
            tail_inst  <= NOP;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            misalign_q <= redirect && tgt_raw[1];
            if (redirect) begin
                fetch_pc <= tgt_aligned;
                count    <= 2'd0;
                if (state == REQ && !bus.imem_ack)
                    kill_addr <= fetch_pc;
            end else begin
                count <= cnt_after;
                if (pop) begin
                    head_pc   <= tail_pc;
                    head_inst <= tail_inst;
                end
                // Push lands in whichever slot is the first free one after this cycle's pop.
                if (push) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    if (cnt_pop == 2'd0) begin
                        head_pc   <= fetch_pc;
                        head_inst <= bus.imem_rdata;
                    end else begin
                        tail_pc   <= fetch_pc;
                        tail_inst <= bus.imem_rdata;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios then random redirects/backpressure against a stream-level model.
module tb_pc_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_fetch_if bus ();
    pc_fetch #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;
    int lat_min = 0;
    int lat_max = 0;
    int lat     = 0;
    int wait_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] target_of(input logic [1:0] code, input logic [12:0] off,
                                              input logic [31:0] bpc, input logic [31:0] jt);
        int soff;
        soff = $signed(off);
        if (code == 2'd2)
            return bpc + 32'(soff);
        return {jt[31:1], 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Instruction memory: each request is answered after a latency drawn at the previous answer.
    always_comb begin
        bus.imem_ack   = bus.imem_req && (wait_cnt >= lat);
        bus.imem_rdata = mem_word(bus.imem_addr);
    end

    always @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 0;
        end else if (bus.imem_req && bus.imem_ack) begin
            wait_cnt <= 0;
            lat      <= $urandom_range(lat_max, lat_min);
        end else if (bus.imem_req) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Monitor / scoreboard: the expected stream is sequential words from the last redirect target.
    initial begin
        logic [31:0] exp_q[$];
        logic        exp_mis;
        logic        hold;
        logic [31:0] hold_pc, hold_inst;
        logic        pend;
        logic [31:0] pend_addr;
        logic [31:0] t, e;
        exp_q   = {RESET_PC};
        exp_mis = 1'b0;
        hold    = 1'b0;
        pend    = 1'b0;
        hold_pc = '0;
        hold_inst = '0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q   = {RESET_PC};
                exp_mis = 1'b0;
                hold    = 1'b0;
                pend    = 1'b0;
            end else begin
                check1("misalign", bus.misalign, exp_mis);
                if (hold) begin
                    check1("hold_valid", bus.inst_valid, 1'b1);
                    check("hold_pc", bus.pc_addr, hold_pc);
                    check("hold_inst", bus.inst_out, hold_inst);
                end
                if (pend) begin
                    check1("req_held", bus.imem_req, 1'b1);
                    check("addr_held", bus.imem_addr, pend_addr);
                end
                if (bus.imem_req)
                    check("addr_align", bus.imem_addr & 32'd3, 32'd0);
                if (bus.inst_valid && bus.inst_ready) begin
                    e = exp_q.pop_front();
                    check("xfer_pc", bus.pc_addr, e);
                    check("xfer_inst", bus.inst_out, mem_word(e));
                    exp_q.push_back(e + 32'd4);
                    n_xfer++;
                end
                pend      = bus.imem_req && !bus.imem_ack;
                pend_addr = bus.imem_addr;
                if (bus.pc_c == 2'd1 || bus.pc_c == 2'd2) begin
                    t       = target_of(bus.pc_c, bus.b_im_in, bus.br_pc, bus.jump_target);
                    exp_q   = {t & ~32'd3};
                    exp_mis = t[1];
                    hold    = 1'b0;
                end else begin
                    exp_mis   = 1'b0;
                    hold      = bus.inst_valid && !bus.inst_ready;
                    hold_pc   = bus.pc_addr;
                    hold_inst = bus.inst_out;
                end
            end
        end
    end

    task automatic set_redir(input logic [1:0] code, input logic [12:0] off,
                             input logic [31:0] bpc, input logic [31:0] jt);
        bus.pc_c        = code;
        bus.b_im_in     = off;
        bus.br_pc       = bpc;
        bus.jump_target = jt;
    endtask

    initial begin
        logic        found;
        logic        got_ack;
        logic [31:0] old_addr;
        int          code;
        rst = 1'b1;
        set_redir(2'd0, 13'd0, 32'd0, 32'd0);
        bus.inst_ready = 1'b1;

        // Reset values and the first sequential fetches.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_req", bus.imem_req, 1'b0);
        check("rst_addr", bus.imem_addr, RESET_PC);
        check1("rst_valid", bus.inst_valid, 1'b0);
        check("rst_inst", bus.inst_out, NOP);
        check("rst_pc", bus.pc_addr, RESET_PC);
        check1("rst_misalign", bus.misalign, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check1("idle_after_rst", bus.imem_req, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check1("seq_req", bus.imem_req, 1'b1);
            check("seq_addr", bus.imem_addr, 32'(4 * k));
            check1("seq_valid", bus.inst_valid, k != 0);
        end

        // Backpressure from reset: queue fills with 0 and 4, then fetch stops.
        @(posedge clk); #1 rst = 1'b1; bus.inst_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        check1("full_req", bus.imem_req, 1'b0);
        check1("full_valid", bus.inst_valid, 1'b1);
        check("full_head_pc", bus.pc_addr, 32'd0);
        check("full_head_inst", bus.inst_out, mem_word(32'd0));
        @(posedge clk); #1 bus.inst_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check1("drain_valid", bus.inst_valid, 1'b1);
        end

        // Taken branch with negative offset.
        @(posedge clk); #1 set_redir(2'd2, 13'h1FF8, 32'h100, 32'd0);
        @(posedge clk); #1 bus.pc_c = 2'd0;
        @(negedge clk);
        check("br_addr", bus.imem_addr, 32'hF8);
        check1("br_req", bus.imem_req, 1'b1);
        check1("br_flush", bus.inst_valid, 1'b0);
        check1("br_misalign", bus.misalign, 1'b0);

        // Jump while a slow fetch is outstanding.
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = bus.imem_req && wait_cnt == 0 && lat == 3;
        end
        check1("slow_req_found", found, 1'b1);
        old_addr = bus.imem_addr;
        @(posedge clk); #1 set_redir(2'd1, 13'd0, 32'd0, 32'h2000);
        @(posedge clk); #1 bus.pc_c = 2'd0;
        got_ack = 1'b0;
        for (int i = 0; i < 8 && !got_ack; i++) begin
            @(negedge clk);
            check("kill_addr_held", bus.imem_addr, old_addr);
            check1("kill_no_valid", bus.inst_valid, 1'b0);
            got_ack = bus.imem_ack;
        end
        check1("kill_ack_seen", got_ack, 1'b1);
        @(negedge clk);
        check("jump_addr", bus.imem_addr, 32'h2000);
        check1("jump_req", bus.imem_req, 1'b1);
        check1("jump_no_valid", bus.inst_valid, 1'b0);

        // Redirect coincident with ack and a transfer.
        lat_min = 0; lat_max = 0;
        repeat (10) @(negedge clk);
        @(posedge clk); #1 set_redir(2'd1, 13'd0, 32'd0, 32'h500);
        @(negedge clk);
        check1("coinc_setup", bus.inst_valid && bus.imem_ack && bus.inst_ready, 1'b1);
        @(posedge clk); #1 bus.pc_c = 2'd0;
        @(negedge clk);
        check1("coinc_flush", bus.inst_valid, 1'b0);
        check("coinc_addr", bus.imem_addr, 32'h500);

        // Misaligned jump target.
        @(posedge clk); #1 set_redir(2'd1, 13'd0, 32'd0, 32'h3006);
        @(posedge clk); #1 bus.pc_c = 2'd3;
        @(negedge clk);
        check1("mis_pulse", bus.misalign, 1'b1);
        check("mis_addr", bus.imem_addr, 32'h3004);
        @(negedge clk);
        check1("mis_end", bus.misalign, 1'b0);

        // Random traffic, with one mid-run reset.
        lat_min = 0; lat_max = 3;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst = (c >= 1500 && c < 1502);
            bus.inst_ready  = ($urandom_range(3, 0) != 0);
            bus.b_im_in     = 13'($urandom);
            bus.br_pc       = $urandom;
            bus.jump_target = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            if (!rst && $urandom_range(9, 0) == 0) begin
                code = $urandom_range(2, 1);
                bus.pc_c = 2'(code);
            end else begin
                bus.pc_c = ($urandom_range(1, 0) == 1) ? 2'd3 : 2'd0;
            end
        end
        @(posedge clk); #1 bus.pc_c = 2'd0; rst = 1'b0;
        repeat (3) @(negedge clk);
        check1("progress", n_xfer > 300, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch stage feeding the decode/execute path whose branch/jump unit returns the `pc_c` redirect code. It holds the fetch PC and issues one-outstanding requests to instruction memory. Fetched words are buffered in a 2-entry queue and presented to decode with their PC. Redirects from the branch unit (`pc_c`, `b_im_in`) and jump targets flush the queue and kill any in-flight fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `pc_c`  in  2  redirect code: 0 sequential, 1 absolute jump (`jump_target`), 2 taken branch (`br_pc` + sext(`b_im_in`)), 3 no redirect
- `b_im_in`  in  13  branch offset in bytes, two's complement
- `br_pc`  in  32  PC of the branch instruction that produced `pc_c`
- `jump_target`  in  32  absolute jump target (JAL/JALR result)
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, word aligned
- `imem_ack`  in  1  response valid; may arrive in the same cycle as `imem_req`
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`
- `inst_valid`  out  1  queue head valid
- `inst_ready`  in  1  decode accepts head
- `inst_out`  out  32  head instruction
- `pc_addr`  out  32  PC of head instruction
- `misalign`  out  1  one-cycle pulse: redirect target had bit 1 set

## Operation
- Redirect is taken when `pc_c` is 1 or 2. Codes 0 and 3 are no-op.
- Branch target: `br_pc` + {{19{b_im_in[12]}}, b_im_in}, modulo 2^32. Jump target: `jump_target` with bit 0 cleared.
- If target bit 1 = 1: `misalign` pulses the next cycle, and fetch proceeds at target with [1:0] cleared.
- Sequential: `fetch_pc` += 4 after each accepted (non-killed) `imem_ack`. Wraps 32'hFFFF_FFFC -> 0.
- Queue: 2 entries {pc, inst}, count 0..2. `inst_valid` = (count != 0). A transfer occurs when `inst_valid && inst_ready`.
- Request is allowed only when count + outstanding < 2, with the count taken after this cycle's pop.
- State machine:
  - IDLE: `imem_req`=0. Go to REQ when a request is allowed.
  - REQ: `imem_req`=1. `imem_addr`=`fetch_pc`, held stable until `imem_ack`.
    - On ack without redirect: push {fetch_pc, imem_rdata}, advance `fetch_pc`, then go to REQ if a request is still allowed, else IDLE.
    - On redirect without ack: go to KILL.
    - On redirect with ack in the same cycle: drop the data, then go to REQ at the target.
  - KILL: `imem_req`=1, with `imem_addr` still the old address. On ack, drop the data and go to REQ at the latest target.
- Any redirect: queue flushed (count=0), and `fetch_pc` = target. Flush wins over a same-cycle push or pop.
- A later redirect in KILL overwrites the pending target.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `inst_out`=32'h0000_0013 (NOP), `pc_addr`=RESET_PC, `misalign`=0, state IDLE, count 0, `fetch_pc`=RESET_PC.
- `rst` asserted mid-transfer: everything returns to reset values next edge. An outstanding ack arriving after reset is ignored, because the state is IDLE.
- `imem_req` is first asserted in the cycle after `rst` deasserts.
- Fetch latency with ack in the same cycle as req: `imem_req` at cycle N -> `inst_valid` at N+1.
- Redirect sampled at edge E (no outstanding request) -> `imem_req` with target at E+1 -> earliest `inst_valid` at E+2.
- Redirect with a request outstanding: the target is requested the cycle after the killed ack.
- Back-to-back throughput is 1 instruction/cycle with same-cycle ack and `inst_ready`=1.
- `inst_out`/`pc_addr` are stable while `inst_valid && !inst_ready`.

## Test plan
- Reset release, RESET_PC=0, memory acks same cycle, `inst_ready`=1 -> `imem_addr` 0,4,8,… on consecutive cycles; `inst_valid` from cycle 2; `pc_addr` tracks the same sequence.
- `inst_ready`=0 for 5 cycles -> queue holds 2 entries (0, 4); `imem_req`=0; head stays pc 0. Release -> pc 0, 4, 8 in order, with no gap.
- `pc_c`=2, `br_pc`=32'h100, `b_im_in`=13'h1FF8 (-8) -> queue flushed; next `imem_addr`=32'hF8; `misalign`=0.
- Memory ack delayed 3 cycles; redirect `pc_c`=1, `jump_target`=32'h2000 issued one cycle after req -> old address held until ack; ack data dropped; next `imem_addr`=32'h2000; no stale `inst_valid`.
- Redirect coincident with `imem_ack` and `inst_ready` -> data dropped; `inst_valid`=0 next cycle; target fetched next cycle.
- `pc_c`=1, `jump_target`=32'h3006 -> `misalign` pulses 1 cycle; `imem_addr`=32'h3004.
